// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner.
package display_pkg;

  localparam int NDIG_DEFAULT = 4;
  localparam int CODE_W       = 4;
  localparam logic [NDIG_DEFAULT-1:0] ANODES_OFF = '1;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

endpackage

// File: rtl/display_scanner_slot_timer.sv
// Slot/digit counter for the display scanner. The strobes describe the cycle
// about to be entered, so the top can register its outputs in step with cnt.
module scan_slot_timer #(
  parameter int  NDIG         = 4,
  parameter int  DIGIT_CYCLES = 50000,
  parameter int  BLANK_CYCLES = 500,
  localparam int CW           = $clog2(DIGIT_CYCLES),
  localparam int IW           = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic          i_active,
  output logic [IW-1:0] o_nxt_idx,
  output logic          o_slot_start,
  output logic          o_blank_end,
  output logic          o_frame_start
);

  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic          w_wrap;

  always_comb begin
    w_wrap    = (r_cnt == CW'(DIGIT_CYCLES - 1));
    o_nxt_idx = r_idx;
    if (!i_active)
      o_nxt_idx = '0;
    else if (w_wrap)
      o_nxt_idx = (r_idx == IW'(NDIG - 1)) ? '0 : r_idx + 1'b1;
    o_slot_start  = i_en & (~i_active | w_wrap);
    o_frame_start = o_slot_start & (o_nxt_idx == '0);
    o_blank_end   = i_en & i_active & (r_cnt == CW'(BLANK_CYCLES - 1));
  end

  // Leaving IDLE forces a fresh frame: cnt=0, idx=0 on the first active cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (!i_en) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (o_slot_start) begin
      r_cnt <= '0;
      r_idx <= o_nxt_idx;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexes an NDIG-digit hex value onto a shared 7-segment bus, with
// double-buffered loads committed only at frame boundaries.
module display_scanner
  import display_pkg::*;
#(
  parameter int  NDIG         = NDIG_DEFAULT,
  parameter int  DIGIT_CYCLES = 50000,
  parameter int  BLANK_CYCLES = 500,
  localparam int IW           = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_enable,
  input  logic                   i_load,
  input  logic [CODE_W*NDIG-1:0] i_value,
  output logic [CODE_W-1:0]      o_code,
  output logic [NDIG-1:0]        o_anodes,
  output logic                   o_frame_tick
);

  state_t                   r_state;
  logic [CODE_W*NDIG-1:0]   r_disp_val;
  logic [CODE_W*NDIG-1:0]   r_pend_val;
  logic                     r_pend_flag;

  logic [IW-1:0]            w_nxt_idx;
  logic                     w_slot_start;
  logic                     w_blank_end;
  logic                     w_frame_start;
  logic [CODE_W*NDIG-1:0]   w_commit_val;
  logic [CODE_W*NDIG-1:0]   w_src_val;
  logic [CODE_W-1:0]        w_digit;

  scan_slot_timer #(
    .NDIG         (NDIG),
    .DIGIT_CYCLES (DIGIT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_en          (i_enable),
    .i_active      (r_state != IDLE),
    .o_nxt_idx     (w_nxt_idx),
    .o_slot_start  (w_slot_start),
    .o_blank_end   (w_blank_end),
    .o_frame_start (w_frame_start)
  );

  // A load coinciding with the commit edge bypasses the pending buffer.
  always_comb begin
    w_commit_val = r_pend_flag ? r_pend_val : r_disp_val;
    if (i_load)
      w_commit_val = i_value;
    w_src_val = w_frame_start ? w_commit_val : r_disp_val;
    w_digit   = w_src_val[CODE_W*w_nxt_idx +: CODE_W];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_disp_val   <= '0;
      r_pend_val   <= '0;
      r_pend_flag  <= 1'b0;
      o_code       <= '0;
      o_anodes     <= '1;
      o_frame_tick <= 1'b0;
    end else begin
      if (w_frame_start) begin
        r_disp_val  <= w_commit_val;
        r_pend_flag <= 1'b0;
      end else if (i_load) begin
        r_pend_val  <= i_value;
        r_pend_flag <= 1'b1;
      end

      o_frame_tick <= w_frame_start;

      // Anodes stay dark for BLANK_CYCLES so the decoder settles on the new code.
      if (!i_enable) begin
        r_state  <= IDLE;
        o_anodes <= '1;
      end else if (w_slot_start) begin
        r_state  <= BLANK;
        o_anodes <= '1;
        o_code   <= w_digit;
      end else if (w_blank_end) begin
        r_state  <= DRIVE;
        o_anodes <= ~(NDIG'(1) << w_nxt_idx);
      end
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Directed self-checking bench for display_scanner (NDIG=4, 8-cycle slots, 2 blank).
module tb_display_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  code;
  logic [3:0]  anodes;
  logic        frame_tick;

  int total = 0;
  int bad   = 0;

  display_scanner #(
    .NDIG         (4),
    .DIGIT_CYCLES (8),
    .BLANK_CYCLES (2)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (enable),
    .i_load       (load),
    .i_value      (value),
    .o_code       (code),
    .o_anodes     (anodes),
    .o_frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input bit do_code, input logic [3:0] ec,
                     input logic [3:0] ea, input logic eft);
    if (do_code) begin
      total++;
      assert (code === ec) else begin
        bad++;
        $error("FAIL %s code got=%h want=%h", tag, code, ec);
      end
    end
    total++;
    assert (anodes === ea) else begin
      bad++;
      $error("FAIL %s anodes got=%b want=%b", tag, anodes, ea);
    end
    total++;
    assert (frame_tick === eft) else begin
      bad++;
      $error("FAIL %s frame_tick got=%b want=%b", tag, frame_tick, eft);
    end
  endtask

  // Called at the negedge of cycle k=0 of a slot; checks nk cycles, optional load at ldk.
  task automatic slot(input string tag, input logic [3:0] ec, input int idx, input bit ft0,
                      input int nk, input int ldk, input logic [15:0] ldv);
    logic [3:0] drv;
    drv = ~(4'b0001 << idx);
    for (int k = 0; k < nk; k++) begin
      chk(tag, 1'b1, ec, (k < 2) ? 4'b1111 : drv, (k == 0) ? ft0 : 1'b0);
      if (k == ldk) begin
        load  = 1'b1;
        value = ldv;
      end
      @(negedge clk);
      load = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; load = 1'b0; value = '0;
    #12;
    chk("rst", 1'b1, 4'h0, 4'b1111, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle", 1'b1, 4'h0, 4'b1111, 1'b0);
    end

    // 2: load 1234 while idle, then enable
    load = 1'b1; value = 16'h1234;
    @(negedge clk);
    load = 1'b0; enable = 1'b1;
    @(negedge clk);
    slot("f1d0", 4'h4, 0, 1'b1, 8, -1, 16'h0);
    // 3: load ABCD mid-digit-1; current frame must not tear
    slot("f1d1", 4'h3, 1, 1'b0, 8, 3, 16'hABCD);
    slot("f1d2", 4'h2, 2, 1'b0, 8, -1, 16'h0);
    slot("f1d3", 4'h1, 3, 1'b0, 8, -1, 16'h0);
    slot("f2d0", 4'hD, 0, 1'b1, 8, -1, 16'h0);
    slot("f2d1", 4'hC, 1, 1'b0, 8, -1, 16'h0);
    slot("f2d2", 4'hB, 2, 1'b0, 8, -1, 16'h0);
    // 4: load 0F0F on the commit edge
    slot("f2d3", 4'hA, 3, 1'b0, 8, 7, 16'h0F0F);
    slot("f3d0", 4'hF, 0, 1'b1, 8, -1, 16'h0);
    slot("f3d1", 4'h0, 1, 1'b0, 8, -1, 16'h0);

    // 5: drop enable at cnt=4 of digit 2
    slot("f3d2", 4'hF, 2, 1'b0, 4, -1, 16'h0);
    chk("f3d2k4", 1'b1, 4'hF, 4'b1011, 1'b0);
    enable = 1'b0;
    @(negedge clk);
    chk("drop", 1'b0, 4'h0, 4'b1111, 1'b0);
    @(negedge clk);
    chk("drop2", 1'b0, 4'h0, 4'b1111, 1'b0);
    enable = 1'b1;
    @(negedge clk);
    slot("re_d0", 4'hF, 0, 1'b1, 8, -1, 16'h0);
    slot("re_d1", 4'h0, 1, 1'b0, 3, -1, 16'h0);
    chk("re_d1k3", 1'b1, 4'h0, 4'b1101, 1'b0);

    // 6: asynchronous reset mid-DRIVE, observed before the next rising edge
    #2 rst_n = 1'b0;
    #1 chk("arst", 1'b1, 4'h0, 4'b1111, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    slot("pr_d0", 4'h0, 0, 1'b1, 8, -1, 16'h0);
    slot("pr_d1", 4'h0, 1, 1'b0, 8, -1, 16'h0);
    slot("pr_d2", 4'h0, 2, 1'b0, 8, -1, 16'h0);
    slot("pr_d3", 4'h0, 3, 1'b0, 8, -1, 16'h0);
    slot("pr_f2", 4'h0, 0, 1'b1, 2, -1, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
